// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode and FSM state types shared by the alu_seq block.
package alu_seq_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SHR,
        ALU_SHL,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_MUL
    } alu_op_e;

    typedef enum logic [0:0] {
        S_IDLE,
        S_MUL_RUN
    } alu_state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add multiplier, one multiplier bit per cycle.
// done is combinational on the final iteration so the caller can register product on that edge.
module alu_seq_mul #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    logic [WIDTH-1:0] acc_q, acc_d, mplr_q, mplr_d, mcand_q, mcand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH:0]   step;

    always_comb begin
        step    = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
        done    = busy_q && cnt_q == CNT_W'(WIDTH - 1);
        product = {step[WIDTH:1], step[0], mplr_q[WIDTH-1:1]};
        acc_d   = start ? '0 : busy_q ? step[WIDTH:1] : acc_q;
        mplr_d  = start ? b : busy_q ? {step[0], mplr_q[WIDTH-1:1]} : mplr_q;
        mcand_d = start ? a : mcand_q;
        cnt_d   = start ? '0 : busy_q ? cnt_q + CNT_W'(1) : cnt_q;
        busy_d  = start | (busy_q & ~done);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            mplr_q  <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            mplr_q  <= mplr_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit ALU with registered result, valid/ready handshake and carry/shift/zero/neg flags.
// Define ALU_SEQ_MUL_EN to build the multi-cycle multiplier for op 7; otherwise op 7 is a one-cycle NOP.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op,
    input  logic             do_carry_in,
    input  logic             do_shift_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             result_valid,
    output logic             flag_carry,
    output logic             flag_shift,
    output logic             flag_zero,
    output logic             flag_neg,
    output logic             a_is_zero
);

    logic [WIDTH-1:0]   result_q, result_d, result_hi_q, result_hi_d;
    logic               valid_q, valid_d, carry_q, carry_d, shift_q, shift_d;
    logic               zero_q, zero_d, neg_q, neg_d;
    logic               sub, cin, fill, accept, upd, mul_done;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] mul_prod;

`ifdef ALU_SEQ_MUL_EN
    alu_state_e state_q, state_d;
    logic       mul_busy;

    assign op_ready = state_q == S_IDLE && !mul_busy;

    alu_seq_mul #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_mul (
        .clk    (clk),
        .reset  (reset),
        .start  (accept && op == ALU_MUL),
        .a      (a),
        .b      (b),
        .busy   (mul_busy),
        .done   (mul_done),
        .product(mul_prod)
    );
`else
    assign op_ready = 1'b1;
    assign mul_done = 1'b0;
    assign mul_prod = '0;
`endif

    always_comb begin
        accept      = op_valid & op_ready;
        sub         = op == ALU_SUB;
        cin         = sub ^ (do_carry_in & carry_q);
        sum         = {1'b0, a} + {1'b0, b ^ {WIDTH{sub}}} + {{WIDTH{1'b0}}, cin};
        fill        = do_shift_in & shift_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        carry_d     = carry_q;
        shift_d     = shift_q;
        valid_d     = 1'b0;
        upd         = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        state_d     = state_q;
`endif
        if (mul_done) begin
            result_d    = mul_prod[WIDTH-1:0];
            result_hi_d = mul_prod[2*WIDTH-1:WIDTH];
            carry_d     = |mul_prod[2*WIDTH-1:WIDTH];
            valid_d     = 1'b1;
            upd         = 1'b1;
`ifdef ALU_SEQ_MUL_EN
            state_d     = S_IDLE;
`endif
        end else if (accept) begin
            valid_d     = 1'b1;
            upd         = 1'b1;
            result_hi_d = '0;
            case (op)
                ALU_ADD, ALU_SUB: begin
                    result_d = sum[WIDTH-1:0];
                    carry_d  = sum[WIDTH];
                end
                ALU_SHR: begin
                    result_d = {fill, a[WIDTH-1:1]};
                    shift_d  = a[0];
                end
                ALU_SHL: begin
                    result_d = {a[WIDTH-2:0], fill};
                    shift_d  = a[WIDTH-1];
                end
                ALU_AND: result_d = a & b;
                ALU_OR:  result_d = a | b;
                ALU_XOR: result_d = a ^ b;
                default: begin
                    // op 7: either launches the multiplier or completes as a flag-preserving NOP
                    result_hi_d = result_hi_q;
                    upd         = 1'b0;
`ifdef ALU_SEQ_MUL_EN
                    valid_d     = 1'b0;
                    state_d     = S_MUL_RUN;
`endif
                end
            endcase
        end
        zero_d = upd ? result_d == '0 : zero_q;
        neg_d  = upd ? result_d[WIDTH-1] : neg_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q    <= '0;
            result_hi_q <= '0;
            valid_q     <= 1'b0;
            carry_q     <= 1'b0;
            shift_q     <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            state_q     <= S_IDLE;
`endif
        end else begin
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            valid_q     <= valid_d;
            carry_q     <= carry_d;
            shift_q     <= shift_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
`ifdef ALU_SEQ_MUL_EN
            state_q     <= state_d;
`endif
        end
    end

    assign result       = result_q;
    assign result_hi    = result_hi_q;
    assign result_valid = valid_q;
    assign flag_carry   = carry_q;
    assign flag_shift   = shift_q;
    assign flag_zero    = zero_q;
    assign flag_neg     = neg_q;
    assign a_is_zero    = a == '0;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed table, hand sequences and randomized ops against an arithmetic model of alu_seq.
// Honours ALU_SEQ_MUL_EN to choose between the multiplier and the NOP behaviour of op 7.
module tb_alu_seq;

    localparam int W = 8;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset, op_valid, do_carry_in, do_shift_in;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         op_ready, result_valid, flag_carry, flag_shift, flag_zero, flag_neg, a_is_zero;
    logic [W-1:0] result, result_hi;

    int checks = 0;
    int failures = 0;
    int m_res, m_hi, m_c, m_s, m_z, m_n;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       dci;
        logic       dsi;
        logic [7:0] res;
        logic       c;
        logic       s;
        logic       z;
        logic       n;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op          (op),
        .do_carry_in (do_carry_in),
        .do_shift_in (do_shift_in),
        .a           (a),
        .b           (b),
        .result      (result),
        .result_hi   (result_hi),
        .result_valid(result_valid),
        .flag_carry  (flag_carry),
        .flag_shift  (flag_shift),
        .flag_zero   (flag_zero),
        .flag_neg    (flag_neg),
        .a_is_zero   (a_is_zero)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".result"}, int'(result), m_res);
        check({tag, ".result_hi"}, int'(result_hi), m_hi);
        check({tag, ".carry"}, int'(flag_carry), m_c);
        check({tag, ".shift"}, int'(flag_shift), m_s);
        check({tag, ".zero"}, int'(flag_zero), m_z);
        check({tag, ".neg"}, int'(flag_neg), m_n);
    endtask

    task automatic model_reset();
        m_res = 0; m_hi = 0; m_c = 0; m_s = 0; m_z = 0; m_n = 0;
    endtask

    // Architectural effect of one completed op, written from the arithmetic meaning of each opcode
    task automatic model_op(input int o, input int x, input int y, input int dci, input int dsi);
        int v, fill;
        fill = dsi & m_s;
        case (o)
            0: begin v = x + y + (dci & m_c); m_c = int'(v > 255); end
            1: begin v = x - y - (dci & m_c); m_c = int'(v >= 0); end
            2: begin v = x / 2 + 128 * fill; m_s = x % 2; end
            3: begin v = (x * 2 + fill) % 256; m_s = x / 128; end
            4: v = x & y;
            5: v = x | y;
            6: v = x ^ y;
            default: begin
                if (!MUL_EN) return;
                v = x * y;
                m_hi = v / 256;
                m_c = int'(m_hi != 0);
            end
        endcase
        if (o != 7) m_hi = 0;
        m_res = v & 255;
        m_z = int'(m_res == 0);
        m_n = int'(m_res >= 128);
    endtask

    task automatic run_op(input int o, input int x, input int y, input int dci, input int dsi, input string tag);
        int n;
        check({tag, ".ready_before"}, int'(op_ready), 1);
        op_valid = 1'b1;
        op = 3'(o);
        a = 8'(x);
        b = 8'(y);
        do_carry_in = 1'(dci);
        do_shift_in = 1'(dsi);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        model_op(o, x, y, dci, dsi);
        if (MUL_EN && o == 7) begin
            n = 1;
            while (!result_valid && n < 20) begin
                check({tag, ".mul_busy_ready"}, int'(op_ready), 0);
                if (n == 3) begin
                    op_valid = 1'b1; op = 3'd0; a = 8'd1; b = 8'd1;
                end
                if (n == 4) op_valid = 1'b0;
                @(posedge clk);
                #1;
                n++;
            end
            check({tag, ".mul_latency"}, n, 9);
        end
        check({tag, ".valid"}, int'(result_valid), 1);
        check({tag, ".ready_after"}, int'(op_ready), 1);
        check_state(tag);
    endtask

    initial begin
        int seen, o, x;
        vecs[0] = '{3'd0, 8'hF0, 8'h20, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{3'd1, 8'h05, 8'h07, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{3'd1, 8'h10, 8'h01, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{3'd2, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{3'd2, 8'h81, 8'h00, 1'b0, 1'b1, 8'hC0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{3'd3, 8'h40, 8'h00, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{3'd4, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{3'd5, 8'h0F, 8'hF0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{3'd6, 8'hAA, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};

        reset = 1'b1; op_valid = 1'b0; op = 3'd0; a = '0; b = '0;
        do_carry_in = 1'b0; do_shift_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check("reset.valid", int'(result_valid), 0);
        check("reset.ready", int'(op_ready), 1);
        check("reset.a_is_zero", int'(a_is_zero), 1);
        check_state("reset");

        // back-to-back directed vectors, flags chained from row to row
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dci, vecs[i].dsi, $sformatf("vec%0d", i));
            check($sformatf("vec%0d.tbl_res", i), int'(result), int'(vecs[i].res));
            check($sformatf("vec%0d.tbl_c", i), int'(flag_carry), int'(vecs[i].c));
            check($sformatf("vec%0d.tbl_s", i), int'(flag_shift), int'(vecs[i].s));
            check($sformatf("vec%0d.tbl_z", i), int'(flag_zero), int'(vecs[i].z));
            check($sformatf("vec%0d.tbl_n", i), int'(flag_neg), int'(vecs[i].n));
        end

        @(posedge clk);
        #1;
        check("hold.valid_drops", int'(result_valid), 0);
        check_state("hold");

`ifdef ALU_SEQ_MUL_EN
        run_op(7, 8'h0F, 8'h11, 0, 0, "mul_0f_11");
        check("mul_0f_11.res", int'(result), 8'hFF);
        check("mul_0f_11.hi", int'(result_hi), 8'h00);
        run_op(7, 8'hFF, 8'hFF, 0, 0, "mul_ff_ff");
        check("mul_ff_ff.res", int'(result), 8'h01);
        check("mul_ff_ff.hi", int'(result_hi), 8'hFE);
        check("mul_ff_ff.carry", int'(flag_carry), 1);
        @(posedge clk);
        #1;
        check("mul_ff_ff.single_pulse", int'(result_valid), 0);

        // reset on the fourth edge of a multiply
        op_valid = 1'b1; op = 3'd7; a = 8'hFF; b = 8'hFF;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            seen |= int'(result_valid);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        seen |= int'(result_valid);
        reset = 1'b0;
        model_reset();
        check("rst_mul.ready", int'(op_ready), 1);
        check_state("rst_mul");
        repeat (10) begin
            @(posedge clk);
            #1;
            seen |= int'(result_valid);
        end
        check("rst_mul.no_valid", seen, 0);
        run_op(0, 1, 1, 0, 0, "rst_mul.add");
        check("rst_mul.add_res", int'(result), 8'h02);
`else
        run_op(0, 8'hF0, 8'h20, 0, 0, "nop.pre_add");
        run_op(7, 8'h55, 8'h33, 1, 1, "nop");
        check("nop.res", int'(result), 8'h10);
        check("nop.carry", int'(flag_carry), 1);
        @(posedge clk);
        #1;
        check("nop.single_pulse", int'(result_valid), 0);
        check("nop.ready", int'(op_ready), 1);
`endif

        for (int i = 0; i < 300; i++) begin
            x = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) begin
                a = 8'(x);
                op_valid = 1'b0;
                #1;
                check("rnd.a_is_zero", int'(a_is_zero), int'(x == 0));
                @(posedge clk);
                #1;
                check("rnd.idle_valid", int'(result_valid), 0);
                check_state("rnd.idle");
            end else begin
                o = int'($urandom_range(0, 7));
                run_op(o, x, int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
                       int'($urandom_range(0, 1)), $sformatf("rnd%0d.op%0d", i, o));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised successor to the 8-bit adder/shifter ALU datapath.
- Generalised to WIDTH bits. Adds:
  - a registered result with a valid/ready handshake
  - logic ops and a left shift
  - zero and negative flags
  - an optional multi-cycle shift-add multiplier
- Sits between the A/B registers and the data-bus driver. The bus driver samples result while result_valid is high.

Parameters:
- WIDTH, 8, operand/result width in bits (≥4).
- CNT_W, $clog2(WIDTH+1), width of the multiply iteration counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- op_valid  input  1  request an operation this cycle.
- op_ready  output  1  block can accept an op (high only in IDLE).
- op  input  3  0 ADD, 1 SUB, 2 SHR, 3 SHL, 4 AND, 5 OR, 6 XOR, 7 MUL.
- do_carry_in  input  1  use flag_carry as carry/borrow-in for ADD/SUB.
- do_shift_in  input  1  use flag_shift as the fill bit for SHR/SHL.
- a  input  WIDTH  A operand.
- b  input  WIDTH  B operand.
- result  output  WIDTH  registered result (low half for MUL).
- result_hi  output  WIDTH  high half of MUL product; 0 after any other op.
- result_valid  output  1  one-cycle pulse when result is updated.
- flag_carry  output  1  carry flag.
- flag_shift  output  1  shift-out flag.
- flag_zero  output  1  result == 0 for the last completed op.
- flag_neg  output  1  result[WIDTH-1] for the last completed op.
- a_is_zero  output  1  combinational: a == 0.

Behaviour:
- Reset: all outputs/state cleared on the clk edge with reset=1.
  - result, result_hi, all flags, result_valid = 0; state IDLE; op_ready = 1 in the cycle after reset releases.
- Acceptance: an op is accepted on an edge where op_valid & op_ready. op_valid while op_ready=0 is ignored (not queued). Operands are sampled only at acceptance.
- Single-cycle ops (0–6):
  - result/flags update on the accepting edge; result_valid is high the following cycle.
  - Back-to-back acceptance every cycle is allowed.
  - A second op may use the flags produced by the first.
- ADD/SUB:
  - cin = (op==SUB) XOR (do_carry_in & flag_carry).
  - sum = a + (b XOR {WIDTH{sub}}) + cin.
  - flag_carry <= carry-out. For SUB, carry=1 means no borrow.
  - flag_shift unchanged.
- SHR: result = {fill, a[WIDTH-1:1]}, fill = do_shift_in & flag_shift; flag_shift <= a[0].
- SHL: result = {a[WIDTH-2:0], fill}; flag_shift <= a[WIDTH-1].
- SHR/SHL: flag_carry unchanged.
- AND/OR/XOR: flag_carry and flag_shift unchanged.
- All completed ops update flag_zero and flag_neg from the new result.
- MUL (when enabled), FSM IDLE → MUL_RUN → IDLE:
  - On accept: acc = 0, multiplicand = a, multiplier = b, cnt = 0; op_ready drops.
  - Each MUL_RUN cycle: if multiplier[0], acc_hi += multiplicand (WIDTH+1-bit add); then shift {acc, multiplier} right 1; cnt++.
  - After WIDTH iterations: result = low half, result_hi = high half.
  - Flags: flag_carry <= (result_hi != 0); flag_zero/flag_neg from the low half; flag_shift unchanged.
  - result_valid pulses exactly WIDTH+1 cycles after the accepting edge; op_ready returns in that same cycle.
- Reset mid-MUL: aborts. No result_valid; outputs go to their reset values.
- result holds its value between ops; result_valid is never high for more than one consecutive cycle per op.

Optional Feature:
- ALU_SEQ_MUL_EN.
- Defined: MUL as above, including the MUL_RUN state and multiplier datapath.
- Undefined: no multiplier logic. op 7 completes in one cycle as a NOP:
  - result_valid pulses; result, result_hi and all flags are unchanged.
  - op_ready never drops.

Decomposition:
- Package alu_seq_pkg:
  - op enum (ALU_ADD..ALU_MUL, 3-bit)
  - state enum (S_IDLE, S_MUL_RUN)
  - OP_W = 3
- Sub-module alu_seq_mul: the iterative shift-add engine.
  - Inputs: start, a, b. Outputs: busy, done, product[2*WIDTH-1:0].
  - Instantiated only under ALU_SEQ_MUL_EN.
- The top level holds the flags, the single-cycle datapath and the handshake.

Test Plan:
- WIDTH=8, ADD a=0xF0 b=0x20 do_carry_in=0 → result 0x10, flag_carry 1, flag_zero 0; next cycle ADD a=0x00 b=0x00 do_carry_in=1 → result 0x01, flag_carry 0.
- SUB a=0x05 b=0x07 → result 0xFE, flag_carry 0, flag_neg 1. Then SUB a=0x10 b=0x01 do_carry_in=1 (flag_carry=0, so cin=1 XOR 0 = 1) → result 0x0F, flag_carry 1.
- SHR a=0x81 with flag_shift=1, do_shift_in=1 → result 0xC0, flag_shift 1; then SHL a=0x40 do_shift_in=0 → result 0x80, flag_shift 0.
- MUL a=0x0F b=0x11 (MUL_EN) → op_ready low 8 cycles; result_valid exactly 9 cycles after accept; result 0xFF, result_hi 0x00, flag_carry 0. Also 0xFF*0xFF → 0x01/0xFE, flag_carry 1. op_valid pulsed during busy is ignored.
- Reset asserted 4 cycles into a MUL → no result_valid; result/flags 0; op_ready 1 after release; a following ADD 0x01+0x01 → 0x02.
- Without MUL_EN: op 7 after ADD result 0x10 → result_valid next cycle, result stays 0x10, flags unchanged, op_ready stays 1.
